// File: rtl/ccff_chain_loader.sv
// Serializes valid/ready bitstream words MSB-first into a configuration flop chain, pulsing done after CHAIN_LEN shifts.
// Latency: first shift the cycle after a word handshake; done one cycle after the last shift; at least one bubble between words.
// Backpressure: word_ready is high only while waiting for a word; abort or RST returns to idle without further shifts.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 10,
    parameter int WORD_W    = 4,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    output logic              busy,
    output logic              done
);

    localparam int WB_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t            state, state_n;
    logic [WORD_W-1:0] sreg, sreg_n;
    logic [CNT_W-1:0]  remaining, remaining_n;
    logic [WB_W-1:0]   wbits, wbits_n;

    always_ff @(posedge CK) begin
        if (RST) begin
            state     <= IDLE;
            sreg      <= '0;
            remaining <= '0;
            wbits     <= '0;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            remaining <= remaining_n;
            wbits     <= wbits_n;
        end
    end

    always_comb begin
        state_n     = state;
        sreg_n      = sreg;
        remaining_n = remaining;
        wbits_n     = wbits;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n     = LOAD;
                    remaining_n = CNT_W'(CHAIN_LEN);
                end
            end
            LOAD: begin
                // A word handshaken together with abort is swallowed.
                if (abort) begin
                    state_n = IDLE;
                end else if (word_valid) begin
                    sreg_n  = word_data;
                    wbits_n = (32'(remaining) < WORD_W) ? WB_W'(remaining) : WB_W'(WORD_W);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    sreg_n      = sreg << 1;
                    wbits_n     = wbits - 1'b1;
                    remaining_n = remaining - 1'b1;
                    if (wbits == WB_W'(1)) begin
                        state_n = (remaining == CNT_W'(1)) ? DONE : LOAD;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign word_ready = (state == LOAD);
    assign ccff_en    = (state == SHIFT);
    assign ccff_head  = (state == SHIFT) && sreg[WORD_W-1];
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomized scoreboard bench for ccff_chain_loader over several chain/word geometries.
// Expected chain bits are the first CHAIN_LEN bits of the accepted word stream, MSB-first.
module tb_ccff_chain_loader;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : inst
        localparam int CL  = (g == 0) ? 10 : (g == 1) ? 8 : (g == 2) ? 1 : 7;
        localparam int WW  = (g == 3) ? 3 : 4;
        localparam int NB0 = (CL < WW) ? CL : WW;
        localparam int K   = (NB0 - 1 < 3) ? NB0 - 1 : 3;
        localparam logic [63:0] FS = (g == 0) ? 64'hA5C0_0000_0000_0000 :
                                     (g == 1) ? 64'hF000_0000_0000_0000 :
                                     (g == 2) ? 64'h8000_0000_0000_0000 :
                                                64'hB6D5_0000_0000_0000;

        logic          rst, start, abort, word_valid;
        logic [WW-1:0] word_data;
        logic          word_ready, ccff_head, ccff_en, busy, done;
        int            exp_q[$];
        bit            mon_en = 1'b0;
        bit            fin = 1'b0;
        bit            need_done = 1'b0;
        bit            busy_chk = 1'b0;

        ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
            .CK(ck), .RST(rst), .start(start), .abort(abort),
            .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
            .ccff_head(ccff_head), .ccff_en(ccff_en), .busy(busy), .done(done)
        );

        // Monitor: every shift pops one expected bit; the value 2 marks the done pulse.
        always @(negedge ck) begin : mon
            int t;
            if (mon_en) begin
                if (busy_chk) begin
                    check("busy_after_done", busy, 1'b0);
                    busy_chk = 1'b0;
                end
                if (need_done) begin
                    check("done_after_last_shift", done, 1'b1);
                    need_done = 1'b0;
                end
                if (ccff_en) begin
                    if (exp_q.size() == 0 || exp_q[0] == 2) begin
                        check("unexpected_shift", ccff_en, 1'b0);
                    end else begin
                        t = exp_q.pop_front();
                        check("head_bit", ccff_head, t[0]);
                        if (exp_q.size() > 0 && exp_q[0] == 2) need_done = 1'b1;
                    end
                end else begin
                    check("head_zero_when_idle", ccff_head, 1'b0);
                end
                if (done) begin
                    if (exp_q.size() > 0 && exp_q[0] == 2) begin
                        t = exp_q.pop_front();
                        busy_chk = 1'b1;
                    end else begin
                        check("unexpected_done", done, 1'b0);
                    end
                end
            end
        end

        // Modes: 0 fixed words always valid, 1 fixed words with stall, 2 abort mid-word,
        // 3 random, 4 RST mid-word, 5 abort together with a handshake.
        initial begin : drv
            logic [63:0]   fs;
            logic [WW-1:0] w;
            logic          vld, rdy, bz;
            int            mode, pushed, limit, budget, stall, extra, cyc, wi;
            bit            killed;
            fs = FS;
            rst = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = '0;
            repeat (3) @(posedge ck);
            #1;
            check("reset_outputs", {word_ready, ccff_en, ccff_head, busy, done}, 5'b0);
            rst = 1'b0;
            mon_en = 1'b1;
            for (int p = 0; p < 12; p++) begin
                mode = (p < 6) ? p : 3;
                if (K < 1 && (mode == 2 || mode == 4)) mode = 3;
                start = 1'b1;
                @(posedge ck); #1;
                start = 1'b0;
                pushed = 0; budget = 0; stall = 0; wi = 0; killed = 1'b0;
                limit = (mode == 2 || mode == 4) ? K : CL;
                while (pushed < limit && budget < 400) begin
                    budget++;
                    if (mode <= 1) w = fs[63 - wi*WW -: WW];
                    else           w = WW'($urandom);
                    if (mode <= 1)      vld = !(mode == 1 && wi == 1 && word_ready && stall < 5);
                    else if (mode == 5) vld = 1'b1;
                    else                vld = ($urandom_range(0, 3) != 0);
                    if (mode == 1 && wi == 1 && word_ready && stall < 5) stall++;
                    if (mode >= 2 && mode != 5) start = 1'($urandom_range(0, 1));
                    rdy = word_ready;
                    if (mode == 5 && rdy) abort = 1'b1;
                    word_valid = vld;
                    word_data  = w;
                    @(posedge ck); #1;
                    if (vld && rdy) begin
                        if (mode == 5) begin
                            abort  = 1'b0;
                            killed = 1'b1;
                            break;
                        end
                        for (int b = WW - 1; b >= 0; b--) begin
                            if (pushed < limit) begin
                                exp_q.push_back(int'(w[b]));
                                pushed++;
                            end
                        end
                        wi++;
                        if (pushed >= CL) exp_q.push_back(2);
                    end
                end
                start = 1'b0;
                if (mode != 5) check("bits_accepted", pushed, limit);
                if ((mode == 2 || mode == 4) && pushed == limit) begin
                    repeat (K - 1) begin @(posedge ck); #1; end
                    if (mode == 2) abort = 1'b1;
                    else           rst   = 1'b1;
                    @(posedge ck); #1;
                    abort = 1'b0;
                    rst   = 1'b0;
                    killed = 1'b1;
                end
                if (killed) begin
                    word_valid = 1'b0;
                    check("outputs_after_kill", {word_ready, ccff_en, ccff_head, busy, done}, 5'b0);
                end else begin
                    word_valid = 1'b1;
                    extra = 0; cyc = 0;
                    do begin
                        rdy = word_ready;
                        bz  = busy;
                        @(posedge ck); #1;
                        if (rdy) extra++;
                        cyc++;
                    end while (bz && cyc < 50);
                    word_valid = 1'b0;
                    check("extra_handshakes", extra, 0);
                    check("idle_after_program", busy, 1'b0);
                end
                repeat (3) begin @(posedge ck); #1; end
                check("queue_drained", exp_q.size(), 0);
                exp_q.delete();
            end
            fin = 1'b1;
        end
    end

    initial begin : summary
        wait (inst[0].fin && inst[1].fin && inst[2].fin && inst[3].fin);
        repeat (2) @(posedge ck);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: bench did not complete, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
